// File: rtl/condicionador_pkg.sv
// Shared state codes and helpers for the push-button conditioner and its
// 7-segment debug path.
package condicionador_pkg;

  localparam int unsigned NUM_BOTOES = 4;
  localparam int unsigned ESTADO_W   = 4;

  typedef enum logic [ESTADO_W-1:0] {
    ESPERA       = 4'd0,
    FILTRA_PRESS = 4'd1,
    PRESSIONADO  = 4'd2,
    FILTRA_SOLTA = 4'd3,
    INVALIDO     = 4'd4
  } estado_t;

  // True when exactly one button is down.
  function automatic logic eh_um_quente(input logic [NUM_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - NUM_BOTOES'(1))) == '0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer bringing asynchronous levels into the clock domain.
module sincronizador_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// Debounces four push buttons, accepts single-button presses as one-cycle
// events and flags stable multi-button presses.
module condicionador_botoes
  import condicionador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  habilita,
  input  logic [NUM_BOTOES-1:0] botoes_raw,
  output logic                  jogada_feita,
  output logic [NUM_BOTOES-1:0] botoes,
  output logic                  multipla,
  output logic [ESTADO_W-1:0]   db_estado
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BOTOES-1:0] s2;
  estado_t               state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_BOTOES-1:0] amostra_q, amostra_d;
  logic [NUM_BOTOES-1:0] botoes_d;
  logic                  jogada_d, multipla_d;

  sincronizador_2ff #(.WIDTH(NUM_BOTOES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (botoes_raw),
    .q     (s2)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ESPERA;
      cnt_q        <= '0;
      amostra_q    <= '0;
      botoes       <= '0;
      jogada_feita <= 1'b0;
      multipla     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      amostra_q    <= amostra_d;
      botoes       <= botoes_d;
      jogada_feita <= jogada_d;
      multipla     <= multipla_d;
    end
  end

  // Events are emitted on the same edge that enters PRESSIONADO/INVALIDO.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    amostra_d  = amostra_q;
    botoes_d   = botoes;
    jogada_d   = 1'b0;
    multipla_d = 1'b0;
    unique case (state_q)
      ESPERA: begin
        if (s2 != '0) begin
          state_d   = FILTRA_PRESS;
          amostra_d = s2;
          cnt_d     = '0;
        end
      end
      FILTRA_PRESS: begin
        if (s2 == '0) begin
          state_d = ESPERA;
        end else if (s2 != amostra_q) begin
          amostra_d = s2;
          cnt_d     = '0;
        end else if (cnt_q == CNT_MAX) begin
          if (eh_um_quente(amostra_q)) begin
            state_d = PRESSIONADO;
            if (habilita) begin
              jogada_d = 1'b1;
              botoes_d = amostra_q;
            end
          end else begin
            state_d    = INVALIDO;
            multipla_d = habilita;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSIONADO, INVALIDO: begin
        if (s2 == '0) begin
          state_d = FILTRA_SOLTA;
          cnt_d   = '0;
        end
      end
      FILTRA_SOLTA: begin
        if (s2 != '0) begin
          state_d = PRESSIONADO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ESPERA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ESPERA;
    endcase
  end

  assign db_estado = state_q;

endmodule
